// File: rtl/armleo_regfile_pkg.sv
// Shared types and constants for the armleo register file and its
// operand-fetch initiator.
package armleo_regfile_pkg;

  // Default register file geometry; the operand-fetch block must match it.
  localparam int REGFILE_WIDTH      = 32;
  localparam int REGFILE_DEPTH_LOG2 = 5;

  // Architectural zero register index: never read, never forwarded.
  localparam int REG_ZERO = 0;

  // Presentation state of the single operand slot towards issue.
  //   EMPTY : nothing presented
  //   FRESH : operands come straight from the regfile read data this cycle
  //   HELD  : issue stalled; operands come from hold registers
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } opfetch_state_t;

endpackage : armleo_regfile_pkg

// File: rtl/armleo_regfile_fwd_slot.sv
// Per-operand forwarding slot for armleo_regfile_operand_fetch.
// Tracks one source operand from accept to consumption: decides whether a
// regfile read is needed, compares the writeback bus against the source,
// and muxes between regfile data, forwarded data and the hold register.
// Optional feature macro: ARMLEO_OPFETCH_BYPASS_EN (writeback forwarding).
module armleo_regfile_fwd_slot
  import armleo_regfile_pkg::*;
#(
  parameter int WIDTH      = REGFILE_WIDTH,
  parameter int DEPTH_LOG2 = REGFILE_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  opfetch_state_t        state_i,
  input  logic                  accept_i,
  input  logic                  op_ready_i,
  input  logic [DEPTH_LOG2-1:0] req_addr_i,
  input  logic                  req_used_i,
  input  logic                  wb_write_i,
  input  logic [DEPTH_LOG2-1:0] wb_addr_i,
`ifdef ARMLEO_OPFETCH_BYPASS_EN
  input  logic [WIDTH-1:0]      wb_wdata_i,
`endif
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  read_o,
  output logic                  req_match_o,
  output logic [WIDTH-1:0]      operand_o
);

  logic             live_req;
  logic             live_q;
  logic [WIDTH-1:0] fresh_val;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;

  // A source is live only when it is used and not x0; dead sources read as 0.
  assign live_req    = req_used_i && (req_addr_i != DEPTH_LOG2'(REG_ZERO));
  assign read_o      = accept_i && live_req;
  // Writeback hitting the source of the request currently offered by decode.
  assign req_match_o = wb_write_i && live_req && (wb_addr_i == req_addr_i);

  // Remember whether the accepted source was live (i.e. a read was issued).
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else if (accept_i) begin
      live_q <= live_req;
    end
  end

`ifdef ARMLEO_OPFETCH_BYPASS_EN
  logic [DEPTH_LOG2-1:0] addr_q;
  logic                  fwd_q;
  logic [WIDTH-1:0]      fwd_data_q;
  logic                  held_match;

  // Capture source index and any same-cycle writeback at accept; the regfile
  // returns pre-write data on read-during-write, so the latched value wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else if (accept_i) begin
      addr_q     <= req_addr_i;
      fwd_q      <= req_match_o;
      fwd_data_q <= wb_wdata_i;
    end
  end

  // Writeback hitting the source that is currently being presented.
  assign held_match = wb_write_i && live_q && (wb_addr_i == addr_q);
  assign fresh_val  = fwd_q ? fwd_data_q : (live_q ? rdata_i : '0);
`else
  assign fresh_val  = live_q ? rdata_i : '0;
`endif

  // Hold-register next value: capture on stall, track writes while stalled.
  // NOTE: assign the default first so every path writes hold_d; a missing
  // assignment in combinational logic infers a latch.
  always_comb begin
    hold_d = hold_q;
    if (!op_ready_i) begin
      if (state_i == FRESH) begin
        hold_d = fresh_val;
      end
`ifdef ARMLEO_OPFETCH_BYPASS_EN
      if (((state_i == FRESH) || (state_i == HELD)) && held_match) begin
        hold_d = wb_wdata_i;
      end
`endif
    end
  end

  // Hold register; it is a handful of flops, so it is reset along with the
  // rest of the slot state.
  // NOTE: only small register state is reset; large storage arrays such as
  // the regfile itself stay unreset so they can map onto RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Operand presented to issue in the current state.
  always_comb begin
    operand_o = '0;
    case (state_i)
      FRESH:   operand_o = fresh_val;
      HELD:    operand_o = hold_q;
      default: operand_o = '0;
    endcase
  end

endmodule : armleo_regfile_fwd_slot

// File: rtl/armleo_regfile_operand_fetch.sv
// Operand-fetch initiator for armleo_regfile_2r1w.
// Accepts fetch requests from decode, drives the synchronous rs1/rs2 read
// ports, and presents operands plus tag to issue over valid/ready. The
// writeback bus is snooped so read-during-write and stalls never yield
// stale operands.
// Optional feature macro: ARMLEO_OPFETCH_BYPASS_EN
//   defined   : writeback data is forwarded into the operands
//   undefined : a request whose live source is being written is held off
//               one cycle, and stalled operands are frozen at stall entry
module armleo_regfile_operand_fetch
  import armleo_regfile_pkg::*;
#(
  parameter int WIDTH      = REGFILE_WIDTH,
  parameter int DEPTH_LOG2 = REGFILE_DEPTH_LOG2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // decode request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DEPTH_LOG2-1:0] req_rs1_addr,
  input  logic                  req_rs1_used,
  input  logic [DEPTH_LOG2-1:0] req_rs2_addr,
  input  logic                  req_rs2_used,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  // regfile read ports
  output logic                  rs1_read,
  output logic [DEPTH_LOG2-1:0] rs1_addr,
  input  logic [WIDTH-1:0]      rs1_rdata,
  output logic                  rs2_read,
  output logic [DEPTH_LOG2-1:0] rs2_addr,
  input  logic [WIDTH-1:0]      rs2_rdata,
  // writeback snoop
  input  logic                  wb_write,
  input  logic [DEPTH_LOG2-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_wdata,
  // issue side
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [WIDTH-1:0]      op_rs1,
  output logic [WIDTH-1:0]      op_rs2,
  output logic [TAG_WIDTH-1:0]  op_tag
);

  opfetch_state_t       state_q;
  opfetch_state_t       state_d;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 accept;
  logic                 slot_free;
  logic                 rs1_req_match;
  logic                 rs2_req_match;

  assign op_valid  = (state_q != EMPTY);
  // The slot can take a new request when empty or being drained this cycle.
  assign slot_free = !op_valid || op_ready;

`ifdef ARMLEO_OPFETCH_BYPASS_EN
  // Forwarding handles write hazards, so the request-side match is not needed.
  logic unused_req_match;
  assign unused_req_match = rs1_req_match | rs2_req_match;
  assign req_ready        = rst_n && slot_free;
`else
  // Without forwarding the write data is never captured here.
  logic unused_wb_wdata;
  assign unused_wb_wdata = ^wb_wdata;
  // Retry next cycle when a live source is being written, so the read
  // returns post-write data.
  assign req_ready       = rst_n && slot_free && !(rs1_req_match || rs2_req_match);
`endif

  assign accept   = req_valid && req_ready;
  assign rs1_addr = req_rs1_addr;
  assign rs2_addr = req_rs2_addr;
  assign op_tag   = tag_q;

  // Next-state logic for the presentation slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FRESH;
      end
      FRESH, HELD: begin
        if (op_ready) state_d = accept ? FRESH : EMPTY;
        else          state_d = HELD;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Tag travels alongside the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if (accept) begin
      tag_q <= req_tag;
    end
  end

  armleo_regfile_fwd_slot #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_slot_rs1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_i     (state_q),
    .accept_i    (accept),
    .op_ready_i  (op_ready),
    .req_addr_i  (req_rs1_addr),
    .req_used_i  (req_rs1_used),
    .wb_write_i  (wb_write),
    .wb_addr_i   (wb_addr),
`ifdef ARMLEO_OPFETCH_BYPASS_EN
    .wb_wdata_i  (wb_wdata),
`endif
    .rdata_i     (rs1_rdata),
    .read_o      (rs1_read),
    .req_match_o (rs1_req_match),
    .operand_o   (op_rs1)
  );

  armleo_regfile_fwd_slot #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_slot_rs2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_i     (state_q),
    .accept_i    (accept),
    .op_ready_i  (op_ready),
    .req_addr_i  (req_rs2_addr),
    .req_used_i  (req_rs2_used),
    .wb_write_i  (wb_write),
    .wb_addr_i   (wb_addr),
`ifdef ARMLEO_OPFETCH_BYPASS_EN
    .wb_wdata_i  (wb_wdata),
`endif
    .rdata_i     (rs2_rdata),
    .read_o      (rs2_read),
    .req_match_o (rs2_req_match),
    .operand_o   (op_rs2)
  );

endmodule : armleo_regfile_operand_fetch

// File: doc/armleo_regfile_operand_fetch.md
Name: armleo_regfile_operand_fetch

Overview:
Read-side initiator for armleo_regfile_2r1w. It accepts operand-fetch requests from decode over valid/ready and drives the synchronous rs1/rs2 read ports. It returns forwarded operands to issue over valid/ready. It snoops the writeback bus, so that read-during-write and writes during a stall never produce stale operands.

Parameters:
WIDTH, 32, register width; must match the regfile.
DEPTH_LOG2, 5, register address width.
TAG_WIDTH, 4, opaque tag carried from request to operand output.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
req_valid  in  1  decode has a request.
req_ready  out  1  block accepts the request this cycle.
req_rs1_addr  in  DEPTH_LOG2  source 1 index.
req_rs1_used  in  1  source 1 is needed.
req_rs2_addr  in  DEPTH_LOG2  source 2 index.
req_rs2_used  in  1  source 2 is needed.
req_tag  in  TAG_WIDTH  request tag.
rs1_read  out  1  regfile port-1 read enable.
rs1_addr  out  DEPTH_LOG2  regfile port-1 address.
rs1_rdata  in  WIDTH  regfile port-1 data; valid the cycle after rs1_read.
rs2_read, rs2_addr, rs2_rdata  as above, for port 2.
wb_write  in  1  writeback strobe; same signal as regfile rd_write.
wb_addr  in  DEPTH_LOG2  writeback index.
wb_wdata  in  WIDTH  writeback data.
op_valid  out  1  operands available.
op_ready  in  1  issue consumes the operands.
op_rs1  out  WIDTH  operand 1.
op_rs2  out  WIDTH  operand 2.
op_tag  out  TAG_WIDTH  tag of the presented request.

Behaviour:
- Reset (rst_n low, async): state EMPTY, op_valid=0, op_rs1/op_rs2/op_tag=0, rs*_read=0, req_ready=0. Any in-flight request is discarded. Accepting resumes the first cycle after deassertion.
- Accept: accept = req_valid && req_ready, with req_ready = rst_n && (!op_valid || op_ready). Throughput is one request per cycle.
- Read drive in accept cycle N:
  - rsX_read = accept && req_rsX_used && (req_rsX_addr != 0).
  - rsX_addr = req_rsX_addr, driven combinationally.
  - A source that is unused or addresses x0 yields operand 0 and issues no read.
- State machine:
  - EMPTY -> FRESH on accept.
  - FRESH: op_valid=1 in cycle N+1. Each operand is taken from rsX_rdata unless the source was forwarded (see write tracking); tag comes from a register.
    - op_ready and accept -> FRESH.
    - op_ready and no accept -> EMPTY.
    - !op_ready -> HELD; forwarded operands are captured into hold registers.
  - HELD: presents hold registers.
    - op_ready and accept -> FRESH.
    - op_ready and no accept -> EMPTY.
    - otherwise remain HELD.
- Write tracking:
  - An accept-cycle match (wb_write && wb_addr==src && src!=0 && used) sets a per-operand forward flag and latches wb_wdata. In FRESH the latched value replaces rsX_rdata, because the regfile returns old data on read-during-write.
  - Writes during FRESH or HELD with op_ready=0 update the matching hold register.
  - A write in the cycle the operand is consumed is not reflected; the scoreboard owns that hazard.
- Writes to x0 never forward.
- rsX_rdata is sampled only in FRESH.
- Same-cycle wb_write matching both sources updates both operands.

Optional Feature:
ARMLEO_OPFETCH_BYPASS_EN.
- Defined: full write tracking as specified above.
- Undefined:
  - No forward flags, latches or hold-register updates.
  - req_ready is additionally forced low when wb_write matches a used, nonzero source of the pending request. The request is retried next cycle and reads post-write data.
  - Hold registers capture once on entry to HELD and are not updated.

Decomposition:
- Package armleo_regfile_pkg holds:
  - the opfetch_state_t enum {EMPTY, FRESH, HELD};
  - the localparam REG_ZERO = 0;
  - the regfile default WIDTH/DEPTH_LOG2 constants.
- Sub-module armleo_regfile_fwd_slot, instantiated once per operand, holds:
  - the per-operand match compare;
  - the forward flag and latch;
  - the hold register and output mux.

Test Plan:
- Basic: regfile x5=0x11, x6=0x22; request rs1=5, rs2=6, op_ready=1 -> op_valid next cycle with op_rs1=0x11, op_rs2=0x22, and rs1_read/rs2_read high for exactly one cycle.
- Read-during-write: accept rs1=7 while wb writes x7=0xDEAD -> op_rs1=0xDEAD (old regfile value discarded).
- Stall: op_ready=0 for 3 cycles; writeback x6=0x99 during stall -> op_rs2=0x99 on release; rs*_read stays low throughout the stall.
- x0/unused: rs1=0 with wb write x0=0xFF, rs2 unused -> op_rs1=0, op_rs2=0, no reads issued.
- Back-to-back: 4 requests with tags 1..4, op_ready=1 -> 4 consecutive op_valid cycles, tags in order, no bubbles.
- Reset: assert rst_n low while in HELD -> op_valid=0 immediately; first accept occurs 1 cycle after release. Repeat with ARMLEO_OPFETCH_BYPASS_EN undefined: the read-during-write case stalls one cycle and then returns 0xDEAD.
